// File: rtl/array_pkg.sv
// Types shared between the array loader (writer) and the downstream array consumer.
package array_pkg;

    localparam int DEPTH_DEFAULT = 64;

    typedef byte byte_array_t [0:DEPTH_DEFAULT-1];

    typedef enum logic [1:0] {FILL, ZERO, HOLD} loader_state_t;

endpackage

// File: rtl/array_loader.sv
// Stream-to-array loader: packs a byte stream into a DEPTH-entry array, zero-fills short
// frames and holds the finished array stable until the consumer acknowledges it.
module array_loader
    import array_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [7:0]          in_data,
    input  logic                       in_last,
    output logic signed [7:0]          array [0:DEPTH-1],
    output logic                       array_valid,
    input  logic                       array_ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic signed [31:0]         running_sum
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    loader_state_t state;
    loader_state_t stateNext;
    logic [PW-1:0] wrPtr;
    logic          transfer;

    // Handshake outputs come straight from the state register, never from inputs.
    assign in_ready    = (state == FILL);
    assign array_valid = (state == HOLD);
    assign transfer    = in_valid && (state == FILL);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= FILL;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            FILL: begin
                if (transfer) begin
                    if (wrPtr == LAST_PTR) begin
                        stateNext = HOLD;
                    end else if (in_last) begin
                        stateNext = ZERO;
                    end
                end
            end
            ZERO: begin
                if (wrPtr == LAST_PTR) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (array_ack) begin
                    stateNext = FILL;
                end
            end
            default: stateNext = FILL;
        endcase
    end

    // The array is not cleared on ack; the next frame overwrites it entry by entry.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrPtr       <= '0;
            count       <= '0;
            running_sum <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                array[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (transfer) begin
                        array[wrPtr] <= in_data;
                        wrPtr        <= wrPtr + PW'(1);
                        count        <= count + CW'(1);
                        running_sum  <= running_sum + 32'(in_data);
                    end
                end
                ZERO: begin
                    array[wrPtr] <= '0;
                    wrPtr        <= wrPtr + PW'(1);
                end
                HOLD: begin
                    if (array_ack) begin
                        wrPtr       <= '0;
                        count       <= '0;
                        running_sum <= '0;
                    end
                end
                default: begin
                    wrPtr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_loader.sv
// Directed self-checking bench for array_loader (DEPTH = 64).
module tb_array_loader;
    import array_pkg::*;

    localparam int DEPTH = 64;

    logic                clock = 1'b0;
    logic                resetN;
    logic                in_valid;
    logic                in_ready;
    logic signed [7:0]   in_data;
    logic                in_last;
    logic signed [7:0]   arr [0:DEPTH-1];
    logic                array_valid;
    logic                array_ack;
    logic [6:0]          count;
    logic signed [31:0]  running_sum;

    int checks = 0;
    int failures = 0;
    byte_array_t expArr;

    array_loader #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .resetN      (resetN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .array       (arr),
        .array_valid (array_valid),
        .array_ack   (array_ack),
        .count       (count),
        .running_sum (running_sum)
    );

    always #5 clock = ~clock;

    // One transfer per call; inputs change 1 time unit after the edge.
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ackCycle();
        array_ack = 1'b1;
        @(posedge clock); #1;
        array_ack = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        resetN = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; array_ack = 1'b0;
        #12;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (arr[i] !== 8'sd0) bad++;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL reset_array: nonzero=%0d expected 0", bad); end
        checks++; if (count !== 7'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (running_sum !== 32'sd0) begin failures++; $display("[TB] FAIL reset_sum: got %0d expected 0", running_sum); end
        checks++; if (array_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", array_valid); end
        resetN = 1'b1;
        @(posedge clock); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_frame();
        int bad;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checks++; if (array_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_early_valid: got %b expected 0", array_valid); end
            end
            applyStimulus(8'(i), 1'b0);
            expArr[i] = 8'(i);
        end
        checks++; if (array_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_valid: got %b expected 1", array_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready: got %b expected 0", in_ready); end
        checks++; if (count !== 7'd64) begin failures++; $display("[TB] FAIL full_count: got %0d expected 64", count); end
        checks++; if (running_sum !== 32'sd2016) begin failures++; $display("[TB] FAIL full_sum: got %0d expected 2016", running_sum); end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (arr[i] !== expArr[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL full_array: wrong_entries=%0d expected 0", bad); end
    endtask

    task automatic test_short_frame();
        int bad;
        int waitCycles;
        ackCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'(i + 1), i == 9);
        end
        checks++; if (array_valid !== 1'b0) begin failures++; $display("[TB] FAIL short_valid_early: got %b expected 0", array_valid); end
        waitCycles = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock); #1;
            if (array_valid === 1'b1) begin
                waitCycles = n;
                break;
            end
        end
        checks++; if (waitCycles != 54) begin failures++; $display("[TB] FAIL short_latency: got %0d cycles expected 54", waitCycles); end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            expArr[i] = (i < 10) ? 8'(i + 1) : 8'sd0;
            if (arr[i] !== expArr[i]) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL short_array: wrong_entries=%0d expected 0", bad); end
        checks++; if (count !== 7'd10) begin failures++; $display("[TB] FAIL short_count: got %0d expected 10", count); end
        checks++; if (running_sum !== 32'sd55) begin failures++; $display("[TB] FAIL short_sum: got %0d expected 55", running_sum); end
    endtask

    task automatic test_hold_backpressure();
        int waitCycles;
        in_valid = 1'b1;
        in_data  = 8'h7F;
        repeat (5) begin
            @(posedge clock); #1;
        end
        checks++; if (arr[0] !== 8'sd1) begin failures++; $display("[TB] FAIL hold_array0: got %0d expected 1", arr[0]); end
        checks++; if (count !== 7'd10) begin failures++; $display("[TB] FAIL hold_count: got %0d expected 10", count); end
        checks++; if (array_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold_valid: got %b expected 1", array_valid); end
        ackCycle();
        checks++; if (array_valid !== 1'b0) begin failures++; $display("[TB] FAIL ack_valid: got %b expected 0", array_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL ack_ready: got %b expected 1", in_ready); end
        checks++; if (count !== 7'd0) begin failures++; $display("[TB] FAIL ack_count: got %0d expected 0", count); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++; if (arr[0] !== 8'sh7F) begin failures++; $display("[TB] FAIL ack_array0: got %0d expected 127", arr[0]); end
        checks++; if (count !== 7'd1) begin failures++; $display("[TB] FAIL ack_count1: got %0d expected 1", count); end
        applyStimulus(8'h05, 1'b1);
        waitCycles = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock); #1;
            if (array_valid === 1'b1) begin
                waitCycles = n;
                break;
            end
        end
        checks++; if (waitCycles != 62) begin failures++; $display("[TB] FAIL hold_k1_latency: got %0d cycles expected 62", waitCycles); end
        ackCycle();
    endtask

    task automatic test_signed_early_ack();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 30) array_ack = 1'b1;
            applyStimulus(8'hFF, 1'b0);
            array_ack = 1'b0;
            if (i == 30) begin
                checks++; if (count !== 7'd31) begin failures++; $display("[TB] FAIL early_ack_count: got %0d expected 31", count); end
                checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL early_ack_ready: got %b expected 1", in_ready); end
            end
        end
        checks++; if (running_sum !== -32'sd64) begin failures++; $display("[TB] FAIL signed_sum: got %0d expected -64", running_sum); end
        checks++; if (count !== 7'd64) begin failures++; $display("[TB] FAIL signed_count: got %0d expected 64", count); end
        checks++; if (arr[63] !== -8'sd1) begin failures++; $display("[TB] FAIL signed_array63: got %0d expected -1", arr[63]); end
        checks++; if (array_valid !== 1'b1) begin failures++; $display("[TB] FAIL signed_valid: got %b expected 1", array_valid); end
        ackCycle();
    endtask

    task automatic test_reset_mid_fill();
        int bad;
        for (int i = 0; i < 20; i++) applyStimulus(8'(i + 3), 1'b0);
        checks++; if (count !== 7'd20) begin failures++; $display("[TB] FAIL midfill_count: got %0d expected 20", count); end
        resetN = 1'b0;
        #3;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (arr[i] !== 8'sd0) bad++;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL midreset_array: nonzero=%0d expected 0", bad); end
        checks++; if (count !== 7'd0) begin failures++; $display("[TB] FAIL midreset_count: got %0d expected 0", count); end
        checks++; if (running_sum !== 32'sd0) begin failures++; $display("[TB] FAIL midreset_sum: got %0d expected 0", running_sum); end
        checks++; if (array_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid: got %b expected 0", array_valid); end
        resetN = 1'b1;
        @(posedge clock); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready: got %b expected 1", in_ready); end
        test_full_frame();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_hold_backpressure();
        test_signed_early_ack();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
